// File: rtl/forward_propagation_engine.sv
// Purpose: sequential 10-5-3 forward pass, one signed MAC per cycle against the shared weight RAM.
// Latency: done pulses 82 cycles after the accepted start edge (N_HID*(N_IN+2) + N_OUT*(N_HID+2) + 1).
// Backpressure: none; start is only sampled in IDLE, and the RAM must return data one cycle after w_rd_en_o.
module forward_propagation_engine #(
    parameter int N_IN    = 10,
    parameter int N_HID   = 5,
    parameter int N_OUT   = 3,
    parameter int DW      = 10,
    parameter int ACC_W   = 24,
    parameter int W1_BASE = 50
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic [N_IN-1:0][DW-1:0]       in_data_i,
    output logic [6:0]                    w_addr_o,
    output logic                          w_rd_en_o,
    input  logic signed [DW-1:0]          w_rdata_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [N_HID-1:0][DW-1:0]      out0_cal_o,
    output logic [N_OUT-1:0][DW-1:0]      out1_cal_o
);

    localparam int KW = $clog2(N_IN + 1);
    localparam int NW = $clog2(N_HID);
    localparam int HW = $clog2(N_HID);
    localparam int OW = $clog2(N_OUT);
    localparam int PW = 2 * DW + 1;

    localparam logic [KW-1:0]          K_HID_LAST = KW'(N_IN);
    localparam logic [KW-1:0]          K_OUT_LAST = KW'(N_HID);
    localparam logic [NW-1:0]          N_HID_LAST = NW'(N_HID - 1);
    localparam logic [NW-1:0]          N_OUT_LAST = NW'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(1 << (DW - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << DW) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_H_MAC, S_H_ACT, S_O_MAC, S_O_ACT, S_DONE
    } state_t;

    state_t                      state_q;
    logic [KW-1:0]               k_q;
    logic [NW-1:0]               n_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic [N_IN-1:0][DW-1:0]     in_q;
    logic [N_HID-1:0][DW-1:0]    out0_q;
    logic [N_OUT-1:0][DW-1:0]    out1_q;
    logic                        busy_q, done_q, rd_en_q;
    logic [6:0]                  addr_q;

    logic [KW-1:0]               op_idx;
    logic [DW-1:0]               op;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_W-1:0]     acc_d;
    logic signed [ACC_W-1:0]     net_w;
    logic signed [ACC_W-1:0]     y_w;
    logic [DW-1:0]               act_y;

    // Operand select, unsigned x signed product, and the saturating linear activation.
    always_comb begin
        op_idx = k_q - KW'(1);
        op     = '0;
        if (k_q != '0) begin
            if (state_q == S_H_MAC) begin
                op = in_q[op_idx];
            end else if (state_q == S_O_MAC) begin
                op = out0_q[op_idx[HW-1:0]];
            end
        end
        prod  = $signed({1'b0, op}) * w_rdata_i;
        acc_d = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
        net_w = acc_q >>> DW;
        y_w   = (net_w <<< 2) + HALF;
        if (y_w[ACC_W-1]) begin
            act_y = '0;
        end else if (y_w > SAT_MAX) begin
            act_y = '1;
        end else begin
            act_y = y_w[DW-1:0];
        end
    end

    // Control FSM: issues reads, accumulates the returning weights, writes each neuron in place.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            in_q    <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        in_q    <= in_data_i;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        n_q     <= '0;
                        k_q     <= '0;
                        rd_en_q <= 1'b1;
                        addr_q  <= '0;
                        state_q <= S_H_MAC;
                    end
                end
                S_H_MAC, S_O_MAC: begin
                    if (k_q != '0) begin
                        acc_q <= acc_d;
                    end
                    if (k_q == ((state_q == S_H_MAC) ? K_HID_LAST : K_OUT_LAST)) begin
                        state_q <= (state_q == S_H_MAC) ? S_H_ACT : S_O_ACT;
                    end else begin
                        k_q <= k_q + KW'(1);
                        // Last read of the neuron was issued this cycle; hold the address.
                        if (k_q == ((state_q == S_H_MAC) ? K_HID_LAST : K_OUT_LAST) - KW'(1)) begin
                            rd_en_q <= 1'b0;
                        end else begin
                            addr_q <= addr_q + 7'd1;
                        end
                    end
                end
                S_H_ACT: begin
                    out0_q[n_q[HW-1:0]] <= act_y;
                    acc_q   <= '0;
                    k_q     <= '0;
                    rd_en_q <= 1'b1;
                    state_q <= S_H_MAC;
                    if (n_q == N_HID_LAST) begin
                        n_q     <= '0;
                        addr_q  <= 7'(W1_BASE);
                        state_q <= S_O_MAC;
                    end else begin
                        n_q    <= n_q + NW'(1);
                        addr_q <= addr_q + 7'd1;
                    end
                end
                S_O_ACT: begin
                    out1_q[n_q[OW-1:0]] <= act_y;
                    acc_q <= '0;
                    k_q   <= '0;
                    if (n_q == N_OUT_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        n_q     <= n_q + NW'(1);
                        addr_q  <= addr_q + 7'd1;
                        rd_en_q <= 1'b1;
                        state_q <= S_O_MAC;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign w_addr_o   = addr_q;
    assign w_rd_en_o  = rd_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign out0_cal_o = out0_q;
    assign out1_cal_o = out1_q;

endmodule

// File: tb/tb_forward_propagation_engine.sv
// Purpose: directed-vector bench for forward_propagation_engine with a 1-cycle-latency weight RAM model.
// Latency: checks done arrives in cycle 82 after start and the exact read schedule of every pass.
// Backpressure: covers start while busy, start in the done cycle, and reset mid-pass.
module tb_forward_propagation_engine;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [9:0][9:0]   in_data;
    logic [6:0]        w_addr;
    logic              w_rd_en;
    logic signed [9:0] w_rdata;
    logic              busy;
    logic              done;
    logic [4:0][9:0]   out0_cal;
    logic [2:0][9:0]   out1_cal;

    logic signed [9:0] wram [0:127];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0]        in0;
        logic [9:0]        in_rest;
        logic signed [9:0] wh0;
        logic signed [9:0] whr;
        logic signed [9:0] wo;
        logic [9:0]        e0;
        logic [9:0]        e1;
    } vec_t;

    vec_t vecs [6];

    forward_propagation_engine dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .in_data_i  (in_data),
        .w_addr_o   (w_addr),
        .w_rd_en_o  (w_rd_en),
        .w_rdata_i  (w_rdata),
        .busy_o     (busy),
        .done_o     (done),
        .out0_cal_o (out0_cal),
        .out1_cal_o (out1_cal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight RAM: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= wram[w_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int a = 0; a < 128; a++) begin
            if (a < 50)      wram[a] = (a % 10 == 0) ? v.wh0 : v.whr;
            else if (a < 65) wram[a] = v.wo;
            else             wram[a] = 10'sd99;
        end
        for (int i = 0; i < 10; i++) in_data[i] = (i == 0) ? v.in0 : v.in_rest;
    endtask

    task automatic chk_outs(input string tag, input logic [9:0] e0, input logic [9:0] e1);
        for (int h = 0; h < 5; h++) chk($sformatf("%s_out0_%0d", tag, h), 64'(out0_cal[h]), 64'(e0));
        for (int o = 0; o < 3; o++) chk($sformatf("%s_out1_%0d", tag, o), 64'(out1_cal[o]), 64'(e1));
    endtask

    // Called at a negedge with the DUT idle. Start is also raised in the done cycle (must be ignored).
    task automatic do_pass(input string tag, input int glitch_at);
        int c, nrd, bad_rd, bad_addr, bad_busy, done_at;
        bit exp_rd;
        c = 1; nrd = 0; bad_rd = 0; bad_addr = 0; bad_busy = 0; done_at = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_at < 0 && c <= 120) begin
            if (c <= 81) exp_rd = (c <= 60) ? (((c - 1) % 12) < 10) : (((c - 61) % 7) < 5);
            else         exp_rd = 1'b0;
            if (w_rd_en !== exp_rd) bad_rd++;
            if (w_rd_en === 1'b1) begin
                if (w_addr !== 7'(nrd)) bad_addr++;
                nrd++;
            end
            if (busy !== 1'b1) bad_busy++;
            if (done === 1'b1) begin
                done_at = c;
                start = 1'b1;
            end
            if (c == glitch_at) begin
                start = 1'b1;
                for (int i = 0; i < 10; i++) in_data[i] = 10'd1023;
            end
            @(negedge clk);
            start = 1'b0;
            c++;
        end
        chk({tag, "_done_cycle"}, 64'(done_at), 64'd82);
        chk({tag, "_rd_schedule_errs"}, 64'(bad_rd), 64'd0);
        chk({tag, "_rd_addr_errs"}, 64'(bad_addr), 64'd0);
        chk({tag, "_rd_count"}, 64'(nrd), 64'd65);
        chk({tag, "_busy_drops"}, 64'(bad_busy), 64'd0);
        chk({tag, "_done_width"}, 64'(done), 64'd0);
        chk({tag, "_idle_after_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        //          in0      in_rest  wh0     whr    wo     e0      e1
        vecs[0] = '{10'd300, 10'd300, 10'sd0, 10'sd0, 10'sd0,   10'd512,  10'd512};
        vecs[1] = '{10'd1023, 10'd0,  10'sd64, 10'sd0, -10'sd64, 10'd764, 10'd0};
        vecs[2] = '{10'd1023, 10'd1023, 10'sd64, 10'sd64, 10'sd0, 10'd1023, 10'd512};
        vecs[3] = '{10'd512, 10'd512, -10'sd64, -10'sd64, 10'sd64, 10'd0, 10'd512};
        vecs[4] = '{10'd512, 10'd0,   10'sd32, 10'sd0, 10'sd16,  10'd576, 10'd692};
        vecs[5] = '{10'd1,   10'd0,   -10'sd1, 10'sd0, 10'sd0,   10'd508, 10'd512};

        rst_n = 1'b0;
        start = 1'b0;
        w_rdata = '0;
        load_vec(vecs[0]);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(w_rd_en), 64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_out0", 64'(out0_cal), 64'd0);
        chk("rst_out1", 64'(out1_cal), 64'd0);

        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            do_pass($sformatf("v%0d", v), -1);
            chk_outs($sformatf("v%0d", v), vecs[v].e0, vecs[v].e1);
        end

        // Start pulse (with new in_data) at cycle 20 must not restart or relatch.
        load_vec(vecs[4]);
        do_pass("glitch", 20);
        chk_outs("glitch", vecs[4].e0, vecs[4].e1);

        // Reset at cycle 40 of a pass discards everything; a fresh pass then completes.
        load_vec(vecs[2]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rd_en", 64'(w_rd_en), 64'd0);
        chk("midrst_w_addr", 64'(w_addr), 64'd0);
        chk("midrst_out0", 64'(out0_cal), 64'd0);
        chk("midrst_out1", 64'(out1_cal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_done", 64'(done), 64'd0);
        do_pass("fresh", -1);
        chk_outs("fresh", vecs[2].e0, vecs[2].e1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
